// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter: buffers each N-sample symbol in a ping-pong RAM and
// re-emits it as the last CP_LEN samples followed by all N samples.
module ofdm_cp_inserter #(
    parameter int DW     = 16,
    parameter int N      = 64,
    parameter int CP_LEN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_en,
    input  logic signed [DW-1:0] inx,
    input  logic signed [DW-1:0] iny,
    output logic                 out_en,
    output logic                 out_sof,
    output logic signed [DW-1:0] outx,
    output logic signed [DW-1:0] outy,
    output logic                 overflow
);

    localparam int            AW       = $clog2(N);
    localparam logic [AW-1:0] CP_START = AW'(N - CP_LEN);
    localparam logic [AW-1:0] LAST     = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, CP, DATA} state_t;

    state_t          state;
    logic [2*DW-1:0] mem [0:2*N-1];
    logic            wbank;
    logic            rbank;
    logic [AW-1:0]   widx;
    logic [AW-1:0]   ridx;
    logic [1:0]      full;
    logic [1:0]      full_next;
    logic            release_now;
    logic            wr_ok;
    logic            wr_last;
    logic [2*DW-1:0] rd_word;

    // A bank released by the reader this cycle may be refilled in the same cycle.
    always_comb begin
        release_now = (state == DATA) && (ridx == LAST);
        wr_ok       = in_en && (!full[wbank] || (release_now && (rbank == wbank)));
        wr_last     = wr_ok && (widx == LAST);
        rd_word     = mem[{rbank, ridx}];
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        full_next = full;
        if (release_now) full_next[rbank] = 1'b0;
        if (wr_last)     full_next[wbank] = 1'b1;
    end

    // NOTE: the sample RAM carries no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[{wbank, widx}] <= {inx, iny};
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            widx     <= '0;
            ridx     <= '0;
            full     <= '0;
            out_en   <= 1'b0;
            out_sof  <= 1'b0;
            outx     <= '0;
            outy     <= '0;
            overflow <= 1'b0;
        end else begin
            full <= full_next;

            if (in_en && !wr_ok) overflow <= 1'b1;
            if (wr_ok) begin
                widx <= widx + 1'b1;
                if (wr_last) wbank <= ~wbank;
            end

            out_en  <= 1'b0;
            out_sof <= 1'b0;
            case (state)
                IDLE: begin
                    if (full[rbank]) begin
                        state <= CP;
                        ridx  <= CP_START;
                    end
                end
                CP: begin
                    out_en  <= 1'b1;
                    out_sof <= (ridx == CP_START);
                    outx    <= rd_word[2*DW-1:DW];
                    outy    <= rd_word[DW-1:0];
                    ridx    <= ridx + 1'b1;
                    if (ridx == LAST) state <= DATA;
                end
                DATA: begin
                    out_en <= 1'b1;
                    outx   <= rd_word[2*DW-1:DW];
                    outy   <= rd_word[DW-1:0];
                    ridx   <= ridx + 1'b1;
                    if (ridx == LAST) begin
                        rbank <= ~rbank;
                        // Registered flag: a bank completing this very cycle is picked up from IDLE.
                        if (full[~rbank]) begin
                            state <= CP;
                            ridx  <= CP_START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Directed bench for ofdm_cp_inserter: ramps in, checks CP+data bursts, timing,
// overflow and asynchronous reset behaviour.
module tb_ofdm_cp_inserter;

    localparam int DW     = 16;
    localparam int N      = 64;
    localparam int CP_LEN = 16;
    localparam int L      = N + CP_LEN;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_en = 1'b0;
    logic signed [DW-1:0] inx   = '0;
    logic signed [DW-1:0] iny   = '0;
    logic                 out_en;
    logic                 out_sof;
    logic signed [DW-1:0] outx;
    logic signed [DW-1:0] outy;
    logic                 overflow;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int ovf_t     = -1;
    int first_cap = 0;

    logic [DW-1:0] cap_x[$];
    logic [DW-1:0] cap_y[$];
    logic          cap_s[$];
    int            cap_t[$];
    int            done_q[$];
    int            exp_base[$];

    ofdm_cp_inserter #(.DW(DW), .N(N), .CP_LEN(CP_LEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_en   (in_en),
        .inx     (inx),
        .iny     (iny),
        .out_en  (out_en),
        .out_sof (out_sof),
        .outx    (outx),
        .outy    (outy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge; stamp is the rising edge that produced it.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_en) begin
                cap_x.push_back(outx);
                cap_y.push_back(outy);
                cap_s.push_back(out_sof);
                cap_t.push_back(cyc);
            end
            if (overflow && ovf_t < 0) ovf_t = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got='h%0h exp='h%0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        cap_x.delete();
        cap_y.delete();
        cap_s.delete();
        cap_t.delete();
        done_q.delete();
        exp_base.delete();
        ovf_t = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_en = 1'b0;
        reset = 1'b1;
        clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_en = 1'b0;
        end
    endtask

    // mode 0: continuous, 1: gaps of 0..2 cycles, 2: occasional single-cycle gap
    task automatic send(input int base, input int first, input int cnt, input int mode);
        for (int i = first; i < first + cnt; i++) begin
            int gap;
            gap = 0;
            if (mode == 1) gap = int'($urandom_range(2, 0));
            if (mode == 2 && $urandom_range(7, 0) == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_en = 1'b0;
            end
            @(negedge clk);
            in_en = 1'b1;
            inx   = DW'(base + i);
            iny   = DW'(-(base + i));
            if (i == first) first_cap = cyc + 1;
            if (((i + 1) % N) == 0) done_q.push_back(cyc + 1);
        end
        @(negedge clk);
        in_en = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int max);
        int n;
        n = 0;
        while (!out_en && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, " out_en seen"}, 64'(out_en), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_en"},   64'(out_en),   64'd0);
        check({tag, " out_sof"},  64'(out_sof),  64'd0);
        check({tag, " outx"},     64'(outx),     64'd0);
        check({tag, " outy"},     64'(outy),     64'd0);
        check({tag, " overflow"}, 64'(overflow), 64'd0);
    endtask

    // Expected burst k starts at max(previous end + 1, completion edge + 2).
    task automatic verify(input string tag);
        int nsym;
        int start;
        int prev_end;
        nsym     = exp_base.size();
        prev_end = -1000;
        check({tag, " len"}, 64'(cap_x.size()), 64'(nsym * L));
        if (cap_x.size() == nsym * L && done_q.size() >= nsym) begin
            for (int k = 0; k < nsym; k++) begin
                start = (prev_end + 1 > done_q[k] + 2) ? prev_end + 1 : done_q[k] + 2;
                check($sformatf("%s sym%0d start", tag, k), 64'(cap_t[k*L]), 64'(start));
                check($sformatf("%s sym%0d span", tag, k),
                      64'(cap_t[k*L+L-1] - cap_t[k*L]), 64'(L - 1));
                prev_end = start + L - 1;
                for (int j = 0; j < L; j++) begin
                    int idx;
                    int v;
                    idx = (j < CP_LEN) ? N - CP_LEN + j : j - CP_LEN;
                    v   = exp_base[k] + idx;
                    check($sformatf("%s sym%0d smp%0d {sof,x,y}", tag, k, j),
                          64'({cap_s[k*L+j], cap_x[k*L+j], cap_y[k*L+j]}),
                          64'({(j == 0), DW'(v), DW'(-v)}));
                end
            end
        end
    endtask

    initial begin
        #2 reset = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single symbol, continuous
        clear();
        exp_base.push_back(0);
        send(0, 0, 64, 0);
        idle(100);
        verify("t1");

        // Two symbols with a 20-cycle gap
        apply_reset();
        exp_base.push_back(0);
        exp_base.push_back(100);
        send(0, 0, 64, 0);
        idle(19);
        send(100, 0, 64, 0);
        idle(100);
        verify("t2");
        check("t2 overflow", 64'(overflow), 64'd0);

        // Random gaps, four symbols
        apply_reset();
        exp_base.push_back(1000);
        exp_base.push_back(1100);
        exp_base.push_back(1200);
        exp_base.push_back(1300);
        send(1000, 0, 64, 1);
        send(1100, 0, 64, 2);
        idle(40);
        send(1200, 0, 64, 1);
        send(1300, 0, 64, 2);
        idle(200);
        verify("t3");
        check("t3 overflow", 64'(overflow), 64'd0);

        // Three continuous symbols: third overflows
        apply_reset();
        exp_base.push_back(0);
        exp_base.push_back(64);
        send(0, 0, 192, 0);
        idle(60);
        verify("t4");
        check("t4 overflow edge", 64'(ovf_t), 64'(first_cap + 128));
        check("t4 overflow sticky", 64'(overflow), 64'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("t4 overflow cleared", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-cycle during the CP of symbol 0
        apply_reset();
        send(200, 0, 64, 0);
        wait_out("t5a", 10);
        check("t5a sof before reset", 64'(out_sof), 64'd1);
        #2 reset = 1'b1;
        #1 check_zero("t5a async");
        clear();
        @(negedge clk);
        reset = 1'b0;
        exp_base.push_back(250);
        send(250, 0, 64, 0);
        idle(100);
        verify("t5a fresh");

        // Reset mid-cycle during input of symbol 1
        apply_reset();
        send(500, 0, 64, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            in_en = 1'b1;
            inx   = DW'(564 + i);
            iny   = DW'(-(564 + i));
        end
        check("t5b out_en before reset", 64'(out_en), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_zero("t5b async");
        clear();
        @(negedge clk);
        in_en = 1'b0;
        reset = 1'b0;
        exp_base.push_back(600);
        send(600, 0, 64, 0);
        idle(100);
        verify("t5b fresh");

        // Partial symbol held indefinitely, then completed
        apply_reset();
        exp_base.push_back(300);
        send(300, 0, 40, 0);
        idle(500);
        check("t6 no output", 64'(cap_x.size()), 64'd0);
        send(300, 40, 24, 0);
        idle(100);
        verify("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
